// File: rtl/config_pkg.sv
// config_pkg: global core configuration shared by the front-end blocks
package config_pkg;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned ILEN;
        int unsigned INSTR_PER_FETCH;
        int unsigned NRET;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{VLEN: 32, ILEN: 32, INSTR_PER_FETCH: 4, NRET: 4};

    localparam int unsigned FQ_DEPTH = 16;

endpackage

// File: rtl/fetch_queue_compact.sv
// fetch_group_compact: per-slot PCs and compacted write offsets for one fetch group
module fetch_group_compact import config_pkg::*; #(
    parameter cfg_t        Cfg = EmptyCfg,
    parameter int unsigned OW  = $clog2(Cfg.INSTR_PER_FETCH + 1)
) (
    input  logic [Cfg.VLEN-1:0]                     fe_pc_i,
    input  logic [Cfg.INSTR_PER_FETCH-1:0]          slot_valid_i,
    output logic [Cfg.INSTR_PER_FETCH*Cfg.VLEN-1:0] slot_pc_o,
    output logic [Cfg.INSTR_PER_FETCH*OW-1:0]       slot_off_o,
    output logic [OW-1:0]                           npush_o
);
    localparam int unsigned IPF  = Cfg.INSTR_PER_FETCH;
    localparam int unsigned VLEN = Cfg.VLEN;

    logic [OW-1:0] acc;

    // Running popcount: a valid slot is written at the number of valid slots below it
    always_comb begin
        acc        = '0;
        slot_pc_o  = '0;
        slot_off_o = '0;
        for (int k = 0; k < IPF; k++) begin
            slot_pc_o[k*VLEN +: VLEN] = fe_pc_i + VLEN'(4 * k);
            slot_off_o[k*OW +: OW]    = acc;
            acc                       = acc + OW'(slot_valid_i[k]);
        end
        npush_o = acc;
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: compacting instruction buffer between fetch and decode
module fetch_queue import config_pkg::*; #(
    parameter cfg_t        Cfg       = EmptyCfg,
    parameter int unsigned DEPTH     = FQ_DEPTH,
    parameter int unsigned DEC_WIDTH = Cfg.NRET
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    flush_i,
    input  logic                                    fe_valid_i,
    output logic                                    fe_ready_o,
    input  logic [Cfg.VLEN-1:0]                     fe_pc_i,
    input  logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0] fe_instrs_i,
    input  logic [Cfg.INSTR_PER_FETCH-1:0]          fe_slot_valid_i,
    output logic [DEC_WIDTH-1:0]                    de_valid_o,
    output logic [DEC_WIDTH*Cfg.ILEN-1:0]           de_instr_o,
    output logic [DEC_WIDTH*Cfg.VLEN-1:0]           de_pc_o,
    input  logic [$clog2(DEC_WIDTH+1)-1:0]          de_accept_i,
    output logic [$clog2(DEPTH+1)-1:0]              count_o
);
    localparam int unsigned VLEN = Cfg.VLEN;
    localparam int unsigned ILEN = Cfg.ILEN;
    localparam int unsigned IPF  = Cfg.INSTR_PER_FETCH;
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned OW   = $clog2(IPF + 1);

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fq_entry_t;

    fq_entry_t           mem [DEPTH];
    logic [PW-1:0]       head_q;
    logic [PW-1:0]       tail_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       npop;
    logic [CW-1:0]       npush_c;
    logic [IPF*VLEN-1:0] slot_pc;
    logic [IPF*OW-1:0]   slot_off;
    logic [OW-1:0]       npush;
    logic                push;

    fetch_group_compact #(.Cfg(Cfg), .OW(OW)) u_compact (
        .fe_pc_i      (fe_pc_i),
        .slot_valid_i (fe_slot_valid_i),
        .slot_pc_o    (slot_pc),
        .slot_off_o   (slot_off),
        .npush_o      (npush)
    );

    // Ready only looks at registered occupancy so it never depends on same-cycle accepts
    assign fe_ready_o = count_q <= CW'(DEPTH - IPF);
    assign push       = fe_valid_i && fe_ready_o && !flush_i;
    assign npop       = (CW'(de_accept_i) > count_q) ? count_q : CW'(de_accept_i);
    assign npush_c    = push ? CW'(npush) : '0;
    assign count_o    = count_q;

    // Storage is written only by enqueue; valid slots land contiguously from tail
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < IPF; k++)
            if (push && fe_slot_valid_i[k])
                mem[tail_q + PW'(slot_off[k*OW +: OW])] <= '{pc: slot_pc[k*VLEN +: VLEN], instr: fe_instrs_i[k*ILEN +: ILEN]};
    end

    // Pointers wrap naturally; flush discards the same-cycle enqueue and dequeue
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(npop);
            tail_q  <= tail_q + PW'(npush_c);
            count_q <= count_q + npush_c - npop;
        end
    end

    // Decode sees the oldest DEC_WIDTH entries straight out of storage, no bypass
    always_comb begin
        de_valid_o = '0;
        de_instr_o = '0;
        de_pc_o    = '0;
        for (int i = 0; i < DEC_WIDTH; i++) begin
            de_valid_o[i]              = count_q > CW'(i);
            de_instr_o[i*ILEN +: ILEN] = mem[head_q + PW'(i)].instr;
            de_pc_o[i*VLEN +: VLEN]    = mem[head_q + PW'(i)].pc;
        end
    end

    accept_within_valid: assert property (@(posedge clk_i) disable iff (!rst_ni) CW'(de_accept_i) <= count_q);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scoreboard bench for fetch_queue
module tb_fetch_queue;
    import config_pkg::*;

    logic         clk_i           = 1'b0;
    logic         rst_ni          = 1'b0;
    logic         flush_i         = 1'b0;
    logic         fe_valid_i      = 1'b0;
    logic         fe_ready_o;
    logic [31:0]  fe_pc_i         = '0;
    logic [127:0] fe_instrs_i     = '0;
    logic [3:0]   fe_slot_valid_i = '0;
    logic [3:0]   de_valid_o;
    logic [127:0] de_instr_o;
    logic [127:0] de_pc_o;
    logic [2:0]   de_accept_i     = '0;
    logic [4:0]   count_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t model [$];

    always #5 clk_i = ~clk_i;

    fetch_queue dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .fe_valid_i      (fe_valid_i),
        .fe_ready_o      (fe_ready_o),
        .fe_pc_i         (fe_pc_i),
        .fe_instrs_i     (fe_instrs_i),
        .fe_slot_valid_i (fe_slot_valid_i),
        .de_valid_o      (de_valid_o),
        .de_instr_o      (de_instr_o),
        .de_pc_o         (de_pc_o),
        .de_accept_i     (de_accept_i),
        .count_o         (count_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; returns 1 time unit after the sampling edge
    task automatic cyc(input logic fv, input logic [31:0] pc, input logic [3:0] m, input logic [2:0] acc, input logic fl);
        fe_valid_i      = fv;
        fe_pc_i         = pc;
        fe_slot_valid_i = m;
        de_accept_i     = acc;
        flush_i         = fl;
        for (int k = 0; k < 4; k++)
            fe_instrs_i[k*32 +: 32] = ~(pc + 32'(4 * k));
        @(posedge clk_i);
        #1;
        fe_valid_i      = 1'b0;
        fe_slot_valid_i = '0;
        de_accept_i     = '0;
        flush_i         = 1'b0;
    endtask

    // Scoreboard update: accepted entries leave the front, accepted groups append compacted
    always @(posedge clk_i or negedge rst_ni) begin
        int sz;
        if (!rst_ni || flush_i) begin
            model.delete();
        end else begin
            sz = model.size();
            for (int i = 0; i < int'(de_accept_i) && model.size() > 0; i++)
                void'(model.pop_front());
            if (fe_valid_i && sz <= 12)
                for (int k = 0; k < 4; k++)
                    if (fe_slot_valid_i[k])
                        model.push_back('{pc: fe_pc_i + 32'(4 * k), instr: fe_instrs_i[k*32 +: 32]});
        end
    end

    // Monitor: compare what decode is shown against the scoreboard every cycle
    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("mon_count", 32'(count_o), 32'(model.size()));
            chk("mon_ready", 32'(fe_ready_o), 32'(model.size() <= 12));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("mon_valid%0d", i), 32'(de_valid_o[i]), 32'(model.size() > i));
                if (i < model.size()) begin
                    chk($sformatf("mon_pc%0d", i), de_pc_o[i*32 +: 32], model[i].pc);
                    chk($sformatf("mon_instr%0d", i), de_instr_o[i*32 +: 32], model[i].instr);
                end
            end
        end
    end

    initial begin
        #3;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_valid", 32'(de_valid_o), 32'h0);
        #9;
        rst_ni = 1'b1;
        #1;
        chk("rst_ready", 32'(fe_ready_o), 32'd1);

        cyc(1'b1, 32'h8000_0000, 4'b1111, 3'd0, 1'b0);
        chk("t1_valid", 32'(de_valid_o), 32'hF);
        chk("t1_count", 32'(count_o), 32'd4);
        chk("t1_pc0", de_pc_o[0 +: 32], 32'h8000_0000);
        chk("t1_pc1", de_pc_o[32 +: 32], 32'h8000_0004);
        chk("t1_pc2", de_pc_o[64 +: 32], 32'h8000_0008);
        chk("t1_pc3", de_pc_o[96 +: 32], 32'h8000_000C);
        chk("t1_instr0", de_instr_o[0 +: 32], 32'h7FFF_FFFF);
        cyc(1'b0, 32'h0, 4'b0000, 3'd4, 1'b0);
        chk("t1_drain", 32'(count_o), 32'd0);

        cyc(1'b1, 32'h0000_0100, 4'b1010, 3'd0, 1'b0);
        chk("t2_count", 32'(count_o), 32'd2);
        chk("t2_valid", 32'(de_valid_o), 32'h3);
        chk("t2_pc0", de_pc_o[0 +: 32], 32'h0000_0104);
        chk("t2_pc1", de_pc_o[32 +: 32], 32'h0000_010C);
        chk("t2_instr1", de_instr_o[32 +: 32], 32'hFFFF_FEF3);
        cyc(1'b1, 32'h0000_0200, 4'b0000, 3'd0, 1'b0);
        chk("t2_zero_mask", 32'(count_o), 32'd2);
        chk("t2_zero_pc0", de_pc_o[0 +: 32], 32'h0000_0104);
        cyc(1'b0, 32'h0, 4'b0000, 3'd2, 1'b0);
        chk("t2_accept_all", 32'(count_o), 32'd0);

        cyc(1'b1, 32'h0000_1000, 4'b1111, 3'd0, 1'b0);
        cyc(1'b1, 32'h0000_2000, 4'b1111, 3'd0, 1'b0);
        cyc(1'b1, 32'h0000_3000, 4'b1111, 3'd0, 1'b0);
        chk("t3_count12", 32'(count_o), 32'd12);
        chk("t3_ready12", 32'(fe_ready_o), 32'd1);
        cyc(1'b1, 32'h0000_4000, 4'b1111, 3'd0, 1'b0);
        chk("t3_count16", 32'(count_o), 32'd16);
        chk("t3_ready16", 32'(fe_ready_o), 32'd0);
        cyc(1'b1, 32'h0000_5000, 4'b1111, 3'd0, 1'b0);
        chk("t3_full_hold", 32'(count_o), 32'd16);
        cyc(1'b0, 32'h0, 4'b0000, 3'd4, 1'b0);
        chk("t3_count_pop", 32'(count_o), 32'd12);
        chk("t3_ready_again", 32'(fe_ready_o), 32'd1);
        chk("t3_pc0", de_pc_o[0 +: 32], 32'h0000_2000);
        repeat (3) cyc(1'b0, 32'h0, 4'b0000, 3'd4, 1'b0);
        chk("t3_drain", 32'(count_o), 32'd0);

        cyc(1'b1, 32'h0000_6000, 4'b1111, 3'd0, 1'b0);
        cyc(1'b1, 32'h0000_6100, 4'b1111, 3'd0, 1'b0);
        repeat (2) cyc(1'b0, 32'h0, 4'b0000, 3'd4, 1'b0);
        cyc(1'b1, 32'h0000_7000, 4'b1111, 3'd0, 1'b0);
        cyc(1'b1, 32'h0000_7100, 4'b1111, 3'd0, 1'b0);
        chk("t4_count", 32'(count_o), 32'd8);
        chk("t4_pc0", de_pc_o[0 +: 32], 32'h0000_7000);
        chk("t4_pc2", de_pc_o[64 +: 32], 32'h0000_7008);
        chk("t4_pc3", de_pc_o[96 +: 32], 32'h0000_700C);
        cyc(1'b0, 32'h0, 4'b0000, 3'd4, 1'b0);
        chk("t4_wrap_pc0", de_pc_o[0 +: 32], 32'h0000_7100);
        chk("t4_wrap_pc3", de_pc_o[96 +: 32], 32'h0000_710C);
        cyc(1'b0, 32'h0, 4'b0000, 3'd4, 1'b0);
        chk("t4_drain", 32'(count_o), 32'd0);

        cyc(1'b1, 32'h0000_8000, 4'b1111, 3'd0, 1'b0);
        cyc(1'b1, 32'h0000_8100, 4'b0001, 3'd0, 1'b0);
        chk("t5_count5", 32'(count_o), 32'd5);
        cyc(1'b1, 32'h0000_9000, 4'b1111, 3'd3, 1'b0);
        chk("t5_count6", 32'(count_o), 32'd6);
        chk("t5_pc0", de_pc_o[0 +: 32], 32'h0000_800C);
        chk("t5_pc1", de_pc_o[32 +: 32], 32'h0000_8100);
        chk("t5_pc2", de_pc_o[64 +: 32], 32'h0000_9000);
        chk("t5_pc3", de_pc_o[96 +: 32], 32'h0000_9004);
        cyc(1'b1, 32'h0000_A000, 4'b0011, 3'd0, 1'b0);
        chk("t5_count8", 32'(count_o), 32'd8);
        cyc(1'b1, 32'h0000_B000, 4'b1111, 3'd2, 1'b1);
        chk("t5_flush_count", 32'(count_o), 32'd0);
        chk("t5_flush_valid", 32'(de_valid_o), 32'h0);

        cyc(1'b1, 32'h0000_D000, 4'b1111, 3'd0, 1'b0);
        cyc(1'b1, 32'h0000_D100, 4'b1111, 3'd0, 1'b0);
        cyc(1'b1, 32'h0000_D200, 4'b0001, 3'd0, 1'b0);
        chk("t6_count9", 32'(count_o), 32'd9);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_async_valid", 32'(de_valid_o), 32'h0);
        chk("t6_async_count", 32'(count_o), 32'd0);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        cyc(1'b1, 32'h0000_C000, 4'b1111, 3'd0, 1'b0);
        chk("t6_restart_count", 32'(count_o), 32'd4);
        chk("t6_restart_pc0", de_pc_o[0 +: 32], 32'h0000_C000);
        cyc(1'b0, 32'h0, 4'b0000, 3'd4, 1'b0);
        chk("t6_end_count", 32'(count_o), 32'd0);
        repeat (2) cyc(1'b0, 32'h0, 4'b0000, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
